// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial two's-complement adder, one sum bit per clock
// Optional subtract path enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic [WIDTH-1:0] Y,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q, y_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q, cout_q, ovf_q, busy_q, done_q;

    logic             sum_bit, carry_d, accept, last_bit, seed;
    logic [WIDTH-1:0] acc_d, opb_load;

    assign sum_bit  = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_d  = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
    assign acc_d    = {sum_bit, acc_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // The DONE exit edge also samples start, so held requests issue every WIDTH+1 cycles.
    assign accept   = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef SERIAL_ADDER_SUB_EN
    assign opb_load = sub ? ~B : B;
    assign seed     = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign opb_load   = B;
    assign seed       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                opa_q   <= A;
                opb_q   <= opb_load;
                carry_q <= seed;
                cnt_q   <= '0;
                acc_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        acc_q   <= acc_d;
                        opa_q   <= opa_q >> 1;
                        opb_q   <= opb_q >> 1;
                        carry_q <= carry_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        if (last_bit) begin
                            y_q     <= acc_d;
                            cout_q  <= carry_d;
                            // carry_q here is the carry into the MSB slice
                            ovf_q   <= carry_q ^ carry_d;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign Y         = y_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] A, B;
    logic       sub;
    logic [7:0] Y;
    logic       carry_out, overflow, busy, done;

    int checks = 0;
    int passed = 0;

    serial_adder #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .sub(sub),
        .Y(Y), .carry_out(carry_out), .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            n = i;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) n = 99;
        check({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] ey, input logic ec, input logic ev);
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_run"}, busy, 1);
        wait_done(tag, 8);
        check({tag, "_y"}, Y, ey);
        check({tag, "_cout"}, carry_out, ec);
        check({tag, "_ovf"}, overflow, ev);
        check({tag, "_busy_done"}, busy, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int seen;
        reset = 1'b0; start = 1'b0; A = '0; B = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_y", Y, 0);
        check("rst_flags", {carry_out, overflow, busy, done}, 0);
        reset = 1'b1;

        run_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
`ifdef SERIAL_ADDER_SUB_EN
        run_op("sub_05_03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
`else
        run_op("sub_ign_05_03", 8'h05, 8'h03, 1'b1, 8'h08, 1'b0, 1'b0);
        run_op("sub_ign_80_01", 8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0);
`endif

        // start held high; operands change during RUN
        @(negedge clk);
        A = 8'h11; B = 8'h22; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 8'h40; B = 8'h01;
        wait_done("held1", 8);
        check("held1_y", Y, 8'h33);
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_drop", done, 0);
        check("b2b_busy", busy, 1);
        check("b2b_y_hold", Y, 8'h33);
        wait_done("held2", 8);
        check("held2_y", Y, 8'h41);
        @(negedge clk);
        check("held2_idle", busy, 0);

        // asynchronous reset in the middle of RUN
        A = 8'hAA; B = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_y", Y, 0);
        check("arst_flags", {carry_out, overflow, busy, done}, 0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        check("arst_no_partial", seen, 0);
        run_op("post_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
